// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage.
// Half-word select values name the SRAM address LSB.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        DONE
    } mem_state_e;

    localparam int unsigned ADDR_BASE_DEF = 1024;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_ctrl.sv
// Two-half-word SRAM access sequencer: FSM, wait counter,
// SRAM strobes and the registered load result.
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int SRAM_AW   = 18,
    parameter int SRAM_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               store,
    input  logic               skip,
    input  logic [SRAM_AW-2:0] word_idx,
    input  logic [31:0]        wdata,
    input  logic [15:0]        dq_in,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        dq_out,
    output logic               dq_oe,
    output logic               we_n,
    output logic [31:0]        mem_data,
    output logic               err_set
);

    localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);

    mem_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        rd_lo_q, rd_lo_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               acc;
    logic               half;
    logic               last;

    assign last = (cnt_q == CNT_LAST);

    // State, counter, read data and address hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_lo_q    <= '0;
            mem_data_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_lo_q    <= rd_lo_d;
            mem_data_q <= mem_data_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state logic; the high half is written straight into
    // mem_data on the last ACC_HI edge so the word is visible in DONE,
    // the one cycle in which MEM-WB captures it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_lo_d    = rd_lo_q;
        mem_data_d = mem_data_q;
        err_set    = 1'b0;
        acc        = 1'b0;
        half       = HALF_LO;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = '0;
                    if (skip) begin
                        state_d = DONE;
                        err_set = 1'b1;
                        if (!store) mem_data_d = '0;
                    end else begin
                        state_d = ACC_LO;
                    end
                end
            end
            ACC_LO: begin
                acc  = 1'b1;
                half = HALF_LO;
                if (last) begin
                    cnt_d   = '0;
                    state_d = ACC_HI;
                    if (!store) rd_lo_d = dq_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACC_HI: begin
                acc  = 1'b1;
                half = HALF_HI;
                if (last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!store) mem_data_d = {dq_in, rd_lo_q};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pins: address follows the active half, else holds
    always_comb begin
        addr_d = addr_q;
        if (acc) addr_d = {word_idx, half};
    end

    assign sram_addr = addr_d;
    assign dq_oe     = acc & store;
    assign we_n      = ~(acc & store);
    assign dq_out    = (half == HALF_HI) ? wdata[31:16]
                                         : wdata[15:0];
    assign mem_data  = mem_data_q;
    assign freeze    = req & (state_q != DONE) & ~rst;

endmodule

// File: rtl/stage_mem.sv
// MEM stage: pass-through to MEM-WB, address translation and
// optional range check (MEM_RANGE_CHECK_EN) around sram_ctrl.
module stage_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BASE = ADDR_BASE_DEF,
    parameter int          SRAM_AW   = 18,
    parameter int          SRAM_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wbEnIn,
    input  logic               memREnIn,
    input  logic               memWEnIn,
    input  logic [31:0]        aluResIn,
    input  logic [31:0]        valRmIn,
    input  logic [3:0]         destIn,
    output logic               wbEnOut,
    output logic               memREnOut,
    output logic [31:0]        aluResOut,
    output logic [3:0]         destOut,
    output logic [31:0]        memDataOut,
    output logic               ramFreeze,
    output logic [SRAM_AW-1:0] sramAddr,
    inout  wire  [15:0]        sramDq,
    output logic               sramWeN,
    output logic               addrErr
);

    logic               req;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word_idx;
    logic               oor;
    logic               err_set;
    logic [15:0]        dq_out;
    logic               dq_oe;

    assign wbEnOut   = wbEnIn;
    assign memREnOut = memREnIn;
    assign aluResOut = aluResIn;
    assign destOut   = destIn;

    assign req      = memREnIn | memWEnIn;
    assign offset   = aluResIn - 32'(ADDR_BASE);
    assign word_idx = offset[SRAM_AW:2];

`ifdef MEM_RANGE_CHECK_EN
    logic err_q, err_d;
    logic unused_off;

    assign oor = (aluResIn < 32'(ADDR_BASE))
               | (|offset[31:SRAM_AW+1]);
    assign unused_off = ^offset[1:0];

    // Sticky range error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    // Set on any rejected request
    always_comb begin
        err_d = err_q | err_set;
    end

    assign addrErr = err_q;
`else
    logic unused_off;

    assign oor        = 1'b0;
    assign addrErr    = 1'b0;
    assign unused_off = ^{offset[1:0], offset[31:SRAM_AW+1],
                          err_set};
`endif

    sram_ctrl #(
        .SRAM_AW  (SRAM_AW),
        .SRAM_WAIT(SRAM_WAIT)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .store    (memWEnIn),
        .skip     (oor),
        .word_idx (word_idx),
        .wdata    (valRmIn),
        .dq_in    (sramDq),
        .freeze   (ramFreeze),
        .sram_addr(sramAddr),
        .dq_out   (dq_out),
        .dq_oe    (dq_oe),
        .we_n     (sramWeN),
        .mem_data (memDataOut),
        .err_set  (err_set)
    );

    assign sramDq = dq_oe ? dq_out : 16'bz;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboarded random bench for stage_mem with an SRAM model;
// a second instance covers a multi-cycle wait setting.
module tb_stage_mem;

    localparam int W = 1;

    typedef struct {
        int          frz;
        int          wr;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic        wb;
        logic        ren;
        logic [31:0] md;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wb, ren, wen;
    logic [31:0] alu, rm;
    logic [3:0]  dst;
    logic        wb_o, ren_o, frz, we_n, aerr;
    logic [31:0] alu_o, md;
    logic [3:0]  dst_o;
    logic [17:0] saddr;
    wire  [15:0] dq;

    logic        r3, w3;
    logic [31:0] a3, d3;
    logic        wb3_o, ren3_o, frz3, we3_n, aerr3;
    logic [31:0] alu3_o, md3;
    logic [3:0]  dst3_o;
    logic [17:0] saddr3;
    wire  [15:0] dq3;

    logic [15:0] sram  [0:255];
    logic [15:0] sram3 [0:255];
    logic [31:0] mdl   [0:63];
    logic [31:0] last_md;
    logic        err_m;

    exp_t        q[$];
    logic [17:0] wl_addr[$];
    logic [15:0] wl_data[$];
    int          wr_total = 0;
    int          issued = 0;
    int          done = 0;
    bit          mon_en = 1'b0;
    int          nerr = 0;
    int          nchk = 0;

    stage_mem #(.SRAM_WAIT(W)) dut (
        .clk(clk), .rst(rst),
        .wbEnIn(wb), .memREnIn(ren), .memWEnIn(wen),
        .aluResIn(alu), .valRmIn(rm), .destIn(dst),
        .wbEnOut(wb_o), .memREnOut(ren_o),
        .aluResOut(alu_o), .destOut(dst_o),
        .memDataOut(md), .ramFreeze(frz),
        .sramAddr(saddr), .sramDq(dq),
        .sramWeN(we_n), .addrErr(aerr)
    );

    stage_mem #(.SRAM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst),
        .wbEnIn(1'b1), .memREnIn(r3), .memWEnIn(w3),
        .aluResIn(a3), .valRmIn(d3), .destIn(4'd2),
        .wbEnOut(wb3_o), .memREnOut(ren3_o),
        .aluResOut(alu3_o), .destOut(dst3_o),
        .memDataOut(md3), .ramFreeze(frz3),
        .sramAddr(saddr3), .sramDq(dq3),
        .sramWeN(we3_n), .addrErr(aerr3)
    );

    assign dq  = (we_n && frz) ? sram[saddr[7:0]] : 16'bz;
    assign dq3 = (we3_n && frz3) ? sram3[saddr3[7:0]] : 16'bz;

    always @(posedge clk) begin
        if (!we_n) begin
            sram[saddr[7:0]] <= dq;
            wl_addr.push_back(saddr);
            wl_data.push_back(dq);
            wr_total <= wr_total + 1;
        end
        if (!we3_n) sram3[saddr3[7:0]] <= dq3;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic finish_up();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    endtask

    // Monitor: one completed instruction per unfrozen cycle
    initial begin
        int   frz_cnt;
        int   wr_base;
        exp_t e;
        frz_cnt = 0;
        wr_base = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                frz_cnt = 0;
                wr_base = wr_total;
            end else if (frz) begin
                frz_cnt++;
            end else if (done != issued) begin
                if (q.size() == 0) begin
                    chk("queue_empty", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("freeze_len", frz_cnt, e.frz);
                    chk("sram_writes", wr_total - wr_base, e.wr);
                    chk("alu_out", alu_o, e.alu);
                    chk("dest_out", {28'd0, dst_o}, {28'd0, e.dest});
                    chk("wb_out", {31'd0, wb_o}, {31'd0, e.wb});
                    chk("ren_out", {31'd0, ren_o}, {31'd0, e.ren});
                    chk("mem_data", md, e.md);
                    chk("addr_err", {31'd0, aerr}, {31'd0, e.err});
                end
                frz_cnt = 0;
                wr_base = wr_total;
                done++;
            end
        end
    end

    // kind: 0 ALU, 1 LDR, 2 STR, 3 both enables (store wins)
    task automatic op(input int kind, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] ds);
        exp_t e;
        int   idx;
        bit   oor;
        @(posedge clk);
        #1;
        wb  = (kind != 2);
        ren = (kind == 1 || kind == 3);
        wen = (kind >= 2);
        alu = a;
        rm  = d;
        dst = ds;
        oor = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        oor = (kind != 0) &&
              (a < 32'd1024 || ((a - 32'd1024) >> 2) >= 32'h20000);
`endif
        idx = int'(((a - 32'd1024) >> 2) & 32'd63);
        if (kind >= 2 && !oor) mdl[idx] = d;
        else if (kind == 1) last_md = oor ? 32'd0 : mdl[idx];
        if (oor) err_m = 1'b1;
        e.frz  = (kind == 0) ? 0 : (oor ? 1 : 1 + 2 * W);
        e.wr   = (kind >= 2 && !oor) ? 2 * W : 0;
        e.alu  = a;
        e.dest = ds;
        e.wb   = wb;
        e.ren  = ren;
        e.md   = last_md;
        e.err  = err_m;
        q.push_back(e);
        issued++;
        for (int i = 0; i < 64 && done != issued; i++) begin
            @(negedge clk);
            #1;
        end
        if (done != issued) begin
            chk("op_timeout", 32'd1, 32'd0);
            finish_up();
        end
    endtask

    task automatic op3(input bit st, input logic [31:0] a,
                       input logic [31:0] d, output int n);
        @(posedge clk);
        #1;
        r3 = !st;
        w3 = st;
        a3 = a;
        d3 = d;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!frz3) break;
            n++;
        end
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 256; i++) begin
            sram[i]  = 16'h0;
            sram3[i] = 16'h0;
        end
        for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
        last_md = 32'h0;
        err_m   = 1'b0;
        rst = 1'b1;
        wb  = 1'b0; ren = 1'b0; wen = 1'b1;
        alu = 32'd1028; rm = 32'h1111_2222; dst = 4'd0;
        r3 = 1'b0; w3 = 1'b0; a3 = 32'd1024; d3 = 32'd0;

        // reset with a store request pending
        #2;
        chk("rst_freeze", {31'd0, frz}, 32'd0);
        chk("rst_wen", {31'd0, we_n}, 32'd1);
        chk("rst_mdata", md, 32'd0);
        chk("rst_addr", {14'd0, saddr}, 32'd0);
        chk("rst_err", {31'd0, aerr}, 32'd0);
        @(negedge clk);
        wen = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;

        // directed store / load / ALU
        base = wl_addr.size();
        op(2, 32'd1028, 32'hDEADBEEF, 4'd1);
        chk("wr_count", wl_addr.size() - base, 32'd2);
        if (wl_addr.size() >= base + 2) begin
            chk("wr0_addr", {14'd0, wl_addr[base]}, 32'd2);
            chk("wr0_data", {16'd0, wl_data[base]}, 32'hBEEF);
            chk("wr1_addr", {14'd0, wl_addr[base+1]}, 32'd3);
            chk("wr1_data", {16'd0, wl_data[base+1]}, 32'hDEAD);
        end
        op(1, 32'd1028, 32'h0, 4'd2);
        op(0, 32'd5, 32'h0, 4'd3);

        // random mix over 16 words
        for (int i = 0; i < 40; i++) begin
            int          k;
            logic [31:0] a;
            k = int'($urandom_range(0, 3));
            a = 32'd1024 + 32'($urandom_range(0, 15)) * 4
              + 32'($urandom_range(0, 3));
            if (k == 0) a = $urandom;
            op(k, a, $urandom, 4'($urandom_range(0, 15)));
        end

        // reset in ACC_HI of a store, then restart
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        wb = 1'b0; ren = 1'b0; wen = 1'b1;
        alu = 32'd1040; rm = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("hi_addr", {14'd0, saddr}, 32'd9);
        rst = 1'b1;
        #1;
        chk("rst5_freeze", {31'd0, frz}, 32'd0);
        chk("rst5_wen", {31'd0, we_n}, 32'd1);
        chk("rst5_mdata", md, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("restart_frz", {31'd0, frz}, 32'd1);
        @(posedge clk);
        #1;
        chk("restart_addr", {14'd0, saddr}, 32'd8);
        chk("restart_wen", {31'd0, we_n}, 32'd0);
        for (int i = 0; i < 20 && frz; i++) @(negedge clk);
        chk("restart_done", {31'd0, frz}, 32'd0);
        #1;
        wen = 1'b0;
        mdl[4]  = 32'hCAFEF00D;
        last_md = 32'h0;
        err_m   = 1'b0;
        mon_en  = 1'b1;
        op(1, 32'd1040, 32'h0, 4'd4);
        op(0, 32'd77, 32'h0, 4'd5);

        // multi-cycle wait instance
        op3(1'b1, 32'd1032, 32'h12345678, n);
        chk("w3_st_freeze", n, 32'd7);
        #1;
        w3 = 1'b0;
        op3(1'b0, 32'd1032, 32'h0, n);
        chk("w3_ld_freeze", n, 32'd7);
        chk("w3_ld_data", md3, 32'h12345678);
        #1;
        r3 = 1'b0;

`ifdef MEM_RANGE_CHECK_EN
        base = wl_addr.size();
        op(1, 32'd1000, 32'h0, 4'd6);
        op(2, 32'd900, 32'h55AA55AA, 4'd7);
        op(0, 32'd9, 32'h0, 4'd8);
        chk("oor_writes", wl_addr.size() - base, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("err_cleared", {31'd0, aerr}, 32'd0);
        rst = 1'b0;
`endif

        @(posedge clk);
        finish_up();
    end

endmodule
